// File: rtl/ufs_tx_symbol_sched_if.sv
// ufs_tx_symbol_sched_if: link-side byte handshake plus encoder symbol/disparity bus
interface ufs_tx_symbol_sched_if;
  logic burst_req;
  logic tx_valid;
  logic [7:0] tx_data;
  logic tx_k;
  logic tx_ready;
  logic burst_active;
  logic enc_en;
  logic [7:0] enc_data;
  logic enc_k;
  logic enc_rd_in;
  logic enc_rd_out;
  modport master (
    output burst_req, tx_valid, tx_data, tx_k, enc_rd_out,
    input  tx_ready, burst_active, enc_en, enc_data, enc_k, enc_rd_in
  );
  modport slave (
    input  burst_req, tx_valid, tx_data, tx_k, enc_rd_out,
    output tx_ready, burst_active, enc_en, enc_data, enc_k, enc_rd_in
  );
endinterface

// File: rtl/ufs_tx_symbol_sched.sv
// ufs_tx_symbol_sched: burst framing (PREP/SYNC/DATA/END) and running disparity for an 8b/10b encoder
// UFS_TX_STAT_EN adds saturating symbol and filler counters.
module ufs_tx_symbol_sched #(
  parameter int PREP_CYC = 8,
  parameter int SYNC_LEN = 4,
  parameter logic [7:0] MK0_SYM = 8'hBC,
  parameter logic [7:0] FILL_SYM = 8'h7C,
  parameter logic [7:0] END_SYM = 8'hFD
) (
  input logic clk,
  input logic rst_n,
  ufs_tx_symbol_sched_if.slave bus
`ifdef UFS_TX_STAT_EN
  ,
  output logic [31:0] stat_sym_cnt,
  output logic [15:0] stat_fill_cnt
`endif
);
  localparam int PW = $clog2(PREP_CYC > 0 ? PREP_CYC : 1) + 1;
  localparam int SW = $clog2(SYNC_LEN > 0 ? SYNC_LEN : 1) + 1;
  localparam logic [PW-1:0] PLAST = PW'(PREP_CYC > 0 ? PREP_CYC - 1 : 0);
  localparam logic [SW-1:0] SLAST = SW'(SYNC_LEN > 0 ? SYNC_LEN - 1 : 0);
  typedef enum logic [2:0] {S_IDLE, S_PREP, S_SYNC, S_DATA, S_END} state_t;
  state_t state;
  logic [PW-1:0] pcnt;
  logic [SW-1:0] scnt;
  logic en, k, rd, take;
  logic [7:0] sym;
  assign bus.tx_ready = (state == S_DATA) & bus.burst_req;
  assign bus.burst_active = state != S_IDLE;
  assign bus.enc_en = en;
  assign bus.enc_data = sym;
  assign bus.enc_k = k;
  assign bus.enc_rd_in = rd;
  assign take = bus.tx_ready & bus.tx_valid;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pcnt <= '0;
      scnt <= '0;
      en <= 1'b0;
      sym <= 8'h00;
      k <= 1'b0;
      rd <= 1'b0;
    end else begin
      if (en) rd <= bus.enc_rd_out;
      en <= 1'b0;
      case (state)
        S_IDLE: if (bus.burst_req) begin
          state <= PREP_CYC > 0 ? S_PREP : S_SYNC;
          pcnt <= '0;
          scnt <= '0;
        end
        S_PREP: if (pcnt == PLAST) begin
          state <= S_SYNC;
          scnt <= '0;
        end else pcnt <= pcnt + 1'b1;
        S_SYNC: begin
          en <= 1'b1;
          sym <= MK0_SYM;
          k <= 1'b1;
          if (scnt == SLAST) state <= S_DATA;
          else scnt <= scnt + 1'b1;
        end
        S_DATA: begin
          en <= 1'b1;
          sym <= take ? bus.tx_data : FILL_SYM;
          k <= take ? bus.tx_k : 1'b1;
          if (!bus.burst_req) state <= S_END;
        end
        S_END: begin
          en <= 1'b1;
          sym <= END_SYM;
          k <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`ifdef UFS_TX_STAT_EN
  logic emit, fill;
  assign emit = state inside {S_SYNC, S_DATA, S_END};
  assign fill = (state == S_DATA) & ~take;
  // counted when the symbol is loaded, so the count matches the cycle it is on enc_data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_sym_cnt <= '0;
      stat_fill_cnt <= '0;
    end else begin
      if (emit && !(&stat_sym_cnt)) stat_sym_cnt <= stat_sym_cnt + 1'b1;
      if (fill && !(&stat_fill_cnt)) stat_fill_cnt <= stat_fill_cnt + 1'b1;
    end
  end
`endif
endmodule
